// File: rtl/pulse_stretch_gen.sv
// Pulse stretcher: each accepted pulse yields a HIGH_CYCLES-wide high window plus a GAP_CYCLES gap.
// Optional retriggerable HIGH behaviour is enabled by defining PULSE_STRETCH_RETRIG_EN.
module pulse_stretch_gen #(
  parameter int unsigned HIGH_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned PEND_W      = 4
) (
  input  logic              sys_clk_i,
  input  logic              rst_i,
  input  logic              pulse_i,
  input  logic              clr_ovf_i,
  output logic              level_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pend_cnt_o,
  output logic              overflow_o
);

  localparam int unsigned MaxCycles = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0]   HighLoad = CntW'(HIGH_CYCLES);
  localparam logic [CntW-1:0]   GapLoad  = CntW'(GAP_CYCLES);
  localparam logic [CntW-1:0]   CntOne   = CntW'(1);
  localparam logic [PEND_W-1:0] PendMax  = '1;
  localparam logic [PEND_W-1:0] PendOne  = PEND_W'(1);
  localparam bit                NoGap    = (GAP_CYCLES == 0);

  if (HIGH_CYCLES == 0) begin : gen_bad_high
    $error("pulse_stretch_gen: HIGH_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              level_q, level_d;
  logic              busy_q, busy_d;

  logic cnt_last;
  logic req;
  logic start_slot;
  logic start;
  logic retrig_hit;
  logic pend_inc;
  logic pend_dec;
  logic ovf_set;

  // Start slot / request decode
  always_comb begin
    cnt_last   = (cnt_q == CntOne);
    req        = (pend_q != '0) | pulse_i;
    start_slot = 1'b0;
    unique case (state_q)
      StIdle:  start_slot = 1'b1;
      StGap:   start_slot = cnt_last;
      StHigh:  start_slot = cnt_last & NoGap;
      default: start_slot = 1'b0;
    endcase
    start = start_slot & req;

    retrig_hit = 1'b0;
`ifdef PULSE_STRETCH_RETRIG_EN
    // A pulse mid-window extends the window instead of queueing another one.
    retrig_hit = (state_q == StHigh) & pulse_i & ~start_slot;
`endif

    pend_dec = start & (pend_q != '0);
    // A pulse is queued unless it directly launched a window from an empty queue.
    pend_inc = pulse_i & ~(start & (pend_q == '0)) & ~retrig_hit;
  end

  // Window sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (start) begin
      state_d = StHigh;
      cnt_d   = HighLoad;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
        end
        StHigh: begin
          if (retrig_hit) begin
            cnt_d = HighLoad;
          end else if (cnt_last) begin
            if (!NoGap) begin
              state_d = StGap;
              cnt_d   = GapLoad;
            end else begin
              state_d = StIdle;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        StGap: begin
          if (cnt_last) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CntOne;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Pending queue, overflow flag and registered outputs
  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    if (pend_inc && !pend_dec) begin
      if (pend_q == PendMax) begin
        ovf_set = 1'b1;
      end else begin
        pend_d = pend_q + PendOne;
      end
    end else if (pend_dec && !pend_inc) begin
      pend_d = pend_q - PendOne;
    end

    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    level_d = (state_d == StHigh);
    busy_d  = (state_d != StIdle) | (pend_d != '0);
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  assign level_o    = level_q;
  assign busy_o     = busy_q;
  assign pend_cnt_o = pend_q;
  assign overflow_o = ovf_q;

endmodule

// File: doc/pulse_stretch_gen.md
# pulse_stretch_gen

Converts single-cycle pulses into fixed-width output levels. Each accepted pulse produces one high window of `HIGH_CYCLES` followed by a mandatory low gap of `GAP_CYCLES`. Pulses arriving while a window or gap is active are queued in a saturating pending counter and replayed back-to-back. The block is the companion of the edge-to-pulse detector: it sits after pulse sources and drives LEDs, strobes or slow-domain enables that need a minimum high/low time.

## Interface
- `HIGH_CYCLES`, default 8: output high width in clocks; must be ≥ 1.
- `GAP_CYCLES`, default 2: forced low time between windows in clocks; must be ≥ 0.
- `PEND_W`, default 4: pending counter width; saturates at 2^PEND_W−1.
- `sys_clk_i`, in, 1: the only clock. All logic is on the rising edge.
- `rst_i`, in, 1: reset. Synchronous, active-high.
- `pulse_i`, in, 1: pulse request. Every high cycle counts as one request.
- `clr_ovf_i`, in, 1: clears `overflow_o`.
- `level_o`, out, 1: stretched output, registered.
- `busy_o`, out, 1: high when state ≠ IDLE or `pend_cnt_o` ≠ 0.
- `pend_cnt_o`, out, PEND_W: number of queued requests not yet started.
- `overflow_o`, out, 1: sticky flag; set when a request is dropped.

## Operation
- State machine: IDLE, HIGH, GAP.
- One down-counter serves both HIGH and GAP. Its width is clog2(max(HIGH_CYCLES, GAP_CYCLES)+1).
- Start request: `pend_cnt_o` > 0 or `pulse_i` = 1.
- A start request is taken in any of these start slots:
  - IDLE;
  - the last GAP cycle;
  - the last HIGH cycle, when GAP_CYCLES = 0.
- On a start:
  - enter HIGH and load HIGH_CYCLES;
  - if `pend_cnt_o` > 0, decrement it, and increment it in parallel for `pulse_i`, so the net count is unchanged when both occur;
  - otherwise `pulse_i` itself is consumed.
- HIGH:
  - `level_o` = 1;
  - when the counter expires, go to GAP (load GAP_CYCLES), or start a new window directly if GAP_CYCLES = 0 and a request is present, else go to IDLE.
- GAP:
  - `level_o` = 0;
  - when the counter expires, start a new window if a request is present, else go to IDLE.
- Queueing: a `pulse_i` that is not consumed by a start increments `pend_cnt_o`.
- Saturation: at 2^PEND_W−1, a further increment is dropped and `overflow_o` is set.
- `overflow_o`: cleared by `clr_ovf_i`. If a set and a clear occur in the same cycle, the set wins.
- Reset values: state IDLE, counter 0, `level_o` = 0, `busy_o` = 0, `pend_cnt_o` = 0, `overflow_o` = 0.
- Reset mid-operation: the window is aborted on the next edge and the queue is discarded. `pulse_i` is ignored while `rst_i` = 1.

## Timing
- Latency: `pulse_i` in IDLE at cycle N gives `level_o` = 1 on cycles N+1 … N+HIGH_CYCLES.
- Gap: `level_o` = 0 on cycles N+HIGH_CYCLES+1 … N+HIGH_CYCLES+GAP_CYCLES.
- Queued windows repeat with period HIGH_CYCLES+GAP_CYCLES and no idle cycle between them.
- GAP_CYCLES = 0 with queued requests: `level_o` stays continuously high for k·HIGH_CYCLES cycles.
- `busy_o` and `pend_cnt_o` are registered and update on the same edge as the state.

## Configuration
- `PULSE_STRETCH_RETRIG_EN` defined: retriggerable mode.
  - A `pulse_i` in HIGH that is not the last-cycle start reloads the counter to HIGH_CYCLES.
  - `level_o` then stays high until HIGH_CYCLES cycles after the latest pulse.
  - The pulse is not queued.
  - Pulses in GAP still queue.
- Macro undefined: pulses in HIGH queue as described in Operation.

## Test plan
- Defaults (8/2/4). `pulse_i` at cycle 10 → `level_o` = 1 on cycles 11–18, 0 from 19. `busy_o` = 1 on 11–20, 0 from 21.
- Pulses at 10, 11, 12 → windows 11–18, 21–28, 31–38. `pend_cnt_o` peaks at 2 and is 0 from cycle 31.
- `pulse_i` held high cycles 10–60 → `pend_cnt_o` saturates at 15 and `overflow_o` = 1. After the input drops, windows keep running until the queue is empty. `overflow_o` stays 1 until `clr_ovf_i`, then reads 0. Set + clear in the same cycle → stays 1.
- Pulse at 10, `rst_i` at cycle 14 (one cycle), pulse at 14 → from 15: `level_o` = 0, `pend_cnt_o` = 0, state IDLE. No window from the cycle-14 pulse.
- `pend_cnt_o` = 1 and `pulse_i` on the last GAP cycle → next window starts and `pend_cnt_o` stays 1. GAP_CYCLES = 0, two pulses at 10, 11 → `level_o` high on 11–26 continuously.
- With `PULSE_STRETCH_RETRIG_EN`: pulses at 10, 15 → `level_o` high on 11–23, `pend_cnt_o` stays 0. Without the macro: windows 11–18 and 21–28.
